// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deserialises 11-bit device frames and folds E0/F0 prefixes
// into one key event per keystroke (done_posedge strobe with held key_code/flags).
module ps2_key_decoder #(
  parameter int TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       done_posedge,
  output logic       key_released,
  output logic       extended,
  output logic [7:0] key_code,
  output logic       frame_error
);

  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW > 18) ? TW_RAW : 18;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_NONE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } state_t;

  // Synchronisers reset to 1 so an idle line never looks like a falling edge.
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  logic w_fall;
  logic w_din;
  assign w_fall = r_clk_s3 & ~r_clk_s2;
  assign w_din  = r_dat_s2;

  logic [3:0]    r_cnt;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_to_cnt;

  logic w_timeout;
  logic w_stop_fall;
  logic w_frame_ok;
  logic w_byte_vld;
  logic w_frame_bad;
  logic [7:0] w_byte;

  assign w_timeout   = (r_cnt != 4'd0) && !w_fall && (r_to_cnt == TO_LAST);
  assign w_stop_fall = w_fall && (r_cnt == 4'd10);
  // Odd parity across the eight data bits plus the parity bit, and stop must be 1.
  assign w_frame_ok  = (^r_shift) & w_din;
  assign w_byte_vld  = w_stop_fall & w_frame_ok;
  assign w_frame_bad = (w_stop_fall & ~w_frame_ok) | w_timeout;
  assign w_byte      = r_shift[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_shift <= 9'd0;
    end else if (w_fall) begin
      if (r_cnt == 4'd0) begin
        if (!w_din) begin
          r_cnt <= 4'd1;
        end
      end else if (r_cnt == 4'd10) begin
        r_cnt <= 4'd0;
      end else begin
        r_shift <= {w_din, r_shift[8:1]};
        r_cnt   <= r_cnt + 4'd1;
      end
    end else if (w_timeout) begin
      r_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_fall || (r_cnt == 4'd0) || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_done, r_err, r_rel, r_ext;
  logic [7:0] r_code;
  logic       w_done_nxt, w_rel_nxt, w_ext_nxt;
  logic [7:0] w_code_nxt;
  logic       w_drop;

  // Bytes that are keyboard status/ack responses rather than key codes.
  always_comb begin
    w_drop = 1'b0;
    case (w_byte)
      8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_drop = 1'b1;
      default: w_drop = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_rel_nxt   = r_rel;
    w_ext_nxt   = r_ext;
    w_code_nxt  = r_code;
    if (w_frame_bad) begin
      w_state_nxt = ST_NONE;
    end else if (w_byte_vld) begin
      if (w_byte == 8'hE0) begin
        if (r_state == ST_NONE) begin
          w_state_nxt = ST_E0;
        end else if (r_state == ST_F0) begin
          w_state_nxt = ST_E0F0;
        end
      end else if (w_byte == 8'hF0) begin
        if (r_state == ST_NONE) begin
          w_state_nxt = ST_F0;
        end else if (r_state == ST_E0) begin
          w_state_nxt = ST_E0F0;
        end
      end else if (!(r_state == ST_NONE && w_drop)) begin
        w_done_nxt  = 1'b1;
        w_code_nxt  = w_byte;
        w_rel_nxt   = (r_state == ST_F0) || (r_state == ST_E0F0);
        w_ext_nxt   = (r_state == ST_E0) || (r_state == ST_E0F0);
        w_state_nxt = ST_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_NONE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rel   <= 1'b0;
      r_ext   <= 1'b0;
      r_code  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_frame_bad;
      r_rel   <= w_rel_nxt;
      r_ext   <= w_ext_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign done_posedge = r_done;
  assign frame_error  = r_err;
  assign key_released = r_rel;
  assign extended     = r_ext;
  assign key_code     = r_code;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks events against hand-computed values.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       done_posedge;
  logic       key_released;
  logic       extended;
  logic [7:0] key_code;
  logic       frame_error;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int t_err = 0;
  int t_fall = 0;
  int b_done, b_err;

  ps2_key_decoder #(.TIMEOUT(200)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .done_posedge (done_posedge),
    .key_released (key_released),
    .extended     (extended),
    .key_code     (key_code),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_posedge) n_done <= n_done + 1;
      if (frame_error) begin
        n_err <= n_err + 1;
        t_err <= cyc;
      end
      if (done_posedge && frame_error) n_both <= n_both + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_done = n_done;
    b_err  = n_err;
  endtask

  // Sends the first nbits bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      idle(10);
      ps2_clk = 1'b0;
      t_fall = cyc;
      idle(10);
      ps2_clk = 1'b1;
    end
    idle(4);
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(d, 1'b0, 11);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(5);
    check("rst_done", {31'd0, done_posedge}, 0);
    check("rst_err", {31'd0, frame_error}, 0);
    check("rst_flags", {30'd0, key_released, extended}, 0);
    check("rst_code", {24'd0, key_code}, 0);
    reset = 1'b0;
    idle(5);

    // Make code for 'A'
    snap();
    send(8'h1C);
    check("make_cnt", n_done - b_done, 1);
    check("make_code", {24'd0, key_code}, 32'h1C);
    check("make_rel", {31'd0, key_released}, 0);
    check("make_ext", {31'd0, extended}, 0);
    idle(20);
    check("make_hold", {24'd0, key_code}, 32'h1C);
    check("make_pulse_low", {31'd0, done_posedge}, 0);

    // Break: F0 1C
    snap();
    send(8'hF0);
    check("brk_f0_noev", n_done - b_done, 0);
    send(8'h1C);
    check("brk_cnt", n_done - b_done, 1);
    check("brk_rel", {31'd0, key_released}, 1);
    check("brk_ext", {31'd0, extended}, 0);
    check("brk_code", {24'd0, key_code}, 32'h1C);

    // Extended break: E0 F0 75, then plain 29
    snap();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("xbrk_cnt", n_done - b_done, 1);
    check("xbrk_code", {24'd0, key_code}, 32'h75);
    check("xbrk_flags", {30'd0, key_released, extended}, 32'h3);
    send(8'h29);
    check("plain_code", {24'd0, key_code}, 32'h29);
    check("plain_flags", {30'd0, key_released, extended}, 0);

    // Parity error then a valid frame
    snap();
    send_bits(8'h1C, 1'b1, 11);
    check("par_err", n_err - b_err, 1);
    check("par_noev", n_done - b_done, 0);
    send(8'h1C);
    check("par_after_cnt", n_done - b_done, 1);
    check("par_after_code", {24'd0, key_code}, 32'h1C);

    // Status byte AA in NONE is dropped
    snap();
    send(8'hAA);
    check("drop_noev", n_done - b_done, 0);
    check("drop_code", {24'd0, key_code}, 32'h1C);

    // Error clears a pending F0 prefix
    snap();
    send(8'hF0);
    send_bits(8'h33, 1'b1, 11);
    send(8'h1C);
    check("errclr_err", n_err - b_err, 1);
    check("errclr_rel", {31'd0, key_released}, 0);

    // Timeout on a partial frame
    snap();
    send_bits(8'h5A, 1'b0, 5);
    idle(300);
    check("to_err", n_err - b_err, 1);
    check("to_noev", n_done - b_done, 0);
    check("to_delay", {31'd0, (t_err - t_fall) >= 199 && (t_err - t_fall) <= 206}, 1);
    send(8'h29);
    check("to_after_code", {24'd0, key_code}, 32'h29);
    check("to_after_err", n_err - b_err, 1);

    // Reset mid-frame discards F0 and the partial frame
    send(8'hF0);
    send_bits(8'h12, 1'b0, 4);
    reset = 1'b1;
    idle(3);
    check("mid_rst_code", {24'd0, key_code}, 0);
    check("mid_rst_out", {29'd0, done_posedge, frame_error, key_released}, 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);
    snap();
    send(8'h1C);
    check("mid_rst_cnt", n_done - b_done, 1);
    check("mid_rst_rel", {31'd0, key_released}, 0);
    check("mid_rst_code2", {24'd0, key_code}, 32'h1C);
    check("mid_rst_noerr", n_err - b_err, 0);

    check("never_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
